alu_issue_ctrl: RTL and testbench

//  Sequencer between the WASM operand stack and the combinational ALU. Accepts one numeric op, pops 1-3

---
 rtl/alu_issue_ctrl_pkg.sv | 25 ++
 rtl/alu_issue_ctrl_op_class.sv | 31 +++
 rtl/alu_issue_ctrl.sv | 138 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// ALU issue controller shared types: op encodings and controller states.
// ALU_DIV_TRAP_EN adds the HALT state used by the divide-by-zero trap.
package alu_issue_ctrl_pkg;

  localparam logic [4:0] ALU_OP_SELECT = 5'b00100;
  localparam logic [4:0] ALU_OP_EQZ    = 5'b00101;
  localparam logic [4:0] ALU_OP_DIV_S  = 5'b10110;
  localparam logic [4:0] ALU_OP_DIV_U  = 5'b10111;
  localparam logic [4:0] ALU_OP_REM_S  = 5'b11001;
  localparam logic [4:0] ALU_OP_REM_U  = 5'b11010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP_A,
    ST_POP_B,
    ST_POP_C,
    ST_EXEC,
    ST_PUSH
`ifdef ALU_DIV_TRAP_EN
    ,
    ST_HALT
`endif
  } state_t;

endpackage

// File: rtl/alu_issue_ctrl_op_class.sv
// Op classifier: operand count and div/rem flag for an ALU control code.
// Combinational; independent of ALU_DIV_TRAP_EN.
module alu_op_class
  import alu_issue_ctrl_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] op_code,
  output logic [1:0]      n_operands,
  output logic            is_divrem
);

  logic div_hit;

  assign div_hit = (op_code == OP_W'(ALU_OP_DIV_S))
                || (op_code == OP_W'(ALU_OP_DIV_U))
                || (op_code == OP_W'(ALU_OP_REM_S))
                || (op_code == OP_W'(ALU_OP_REM_U));

  always_comb begin
    n_operands = 2'd2;
    is_divrem  = 1'b0;
    unique case (1'b1)
      (op_code == OP_W'(ALU_OP_EQZ)):    n_operands = 2'd1;
      (op_code == OP_W'(ALU_OP_SELECT)): n_operands = 2'd3;
      div_hit:                           is_divrem  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer: pops operands, drives the parent's ALU, pushes result.
// ALU_DIV_TRAP_EN: trap and halt on a zero divisor for div/rem codes.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int OP_W    = 5,
  parameter int DIV_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [OP_W-1:0]  op_code,
  input  logic             op_len,
  output logic             pop_valid,
  input  logic             pop_ready,
  input  logic [WIDTH-1:0] pop_data,
  output logic             push_valid,
  input  logic             push_ready,
  output logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [WIDTH-1:0] alu_c,
  output logic [OP_W-1:0]  alu_ctrl,
  output logic             alu_len,
  input  logic [WIDTH-1:0] alu_result,
  output logic             busy,
  output logic             trap
);

  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       n_ops;
  logic             is_divrem;
  logic [CNT_W-1:0] exec_cnt;
  logic             exec_last;
  logic             trap_hit;

  alu_op_class #(.OP_W(OP_W)) u_class (
    .op_code    (alu_ctrl),
    .n_operands (n_ops),
    .is_divrem  (is_divrem)
  );

  assign exec_last = !is_divrem
                  || (exec_cnt == CNT_W'(DIV_LAT - 1));

`ifdef ALU_DIV_TRAP_EN
  // i32 divides only look at the low word of the divisor
  logic div_zero;
  assign div_zero = alu_len ? (alu_a == '0)
                            : (alu_a[31:0] == 32'd0);
  assign trap_hit = (state == ST_EXEC) && exec_last
                 && is_divrem && div_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        trap <= 1'b0;
    else if (trap_hit) trap <= 1'b1;
  end
`else
  assign trap_hit = 1'b0;
  assign trap     = 1'b0;
`endif

  assign op_ready   = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign push_valid = (state == ST_PUSH);
  assign pop_valid  = (state == ST_POP_A)
                   || (state == ST_POP_B)
                   || (state == ST_POP_C);

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:
        if (op_valid) state_nxt = ST_POP_A;
      ST_POP_A:
        if (pop_ready)
          state_nxt = (n_ops == 2'd1) ? ST_EXEC : ST_POP_B;
      ST_POP_B:
        if (pop_ready)
          state_nxt = (n_ops == 2'd3) ? ST_POP_C : ST_EXEC;
      ST_POP_C:
        if (pop_ready) state_nxt = ST_EXEC;
      ST_EXEC:
        if (exec_last) begin
`ifdef ALU_DIV_TRAP_EN
          state_nxt = trap_hit ? ST_HALT : ST_PUSH;
`else
          state_nxt = ST_PUSH;
`endif
        end
      ST_PUSH:
        if (push_ready) state_nxt = ST_IDLE;
`ifdef ALU_DIV_TRAP_EN
      ST_HALT:
        state_nxt = ST_HALT;
`endif
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_c     <= '0;
      alu_ctrl  <= '0;
      alu_len   <= 1'b0;
      push_data <= '0;
      exec_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (op_ready && op_valid) begin
        alu_ctrl <= op_code;
        alu_len  <= op_len;
        alu_a    <= '0;
        alu_b    <= '0;
        alu_c    <= '0;
      end
      if (pop_valid && pop_ready) begin
        if (state == ST_POP_A)      alu_a <= pop_data;
        else if (state == ST_POP_B) alu_b <= pop_data;
        else                        alu_c <= pop_data;
      end
      if (state == ST_EXEC) begin
        exec_cnt <= exec_last ? '0 : exec_cnt + CNT_W'(1);
        if (exec_last && !trap_hit) push_data <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: stack queue model plus reference ALU.
// Build with or without ALU_DIV_TRAP_EN; the div-by-zero case adapts.
module tb_alu_issue_ctrl;

  localparam int W  = 64;
  localparam int OW = 5;
  localparam int DL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid, op_ready;
  logic [OW-1:0] op_code;
  logic          op_len;
  logic          pop_valid, pop_ready;
  logic [W-1:0]  pop_data;
  logic          push_valid, push_ready;
  logic [W-1:0]  push_data;
  logic [W-1:0]  alu_a, alu_b, alu_c, alu_result;
  logic [OW-1:0] alu_ctrl;
  logic          alu_len, busy, trap;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0]  stk[$];
  logic [W-1:0]  cap_a, cap_b, cap_c;
  logic [OW-1:0] cap_ctrl;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W), .OP_W(OW), .DIV_LAT(DL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_len     (op_len),
    .pop_valid  (pop_valid),
    .pop_ready  (pop_ready),
    .pop_data   (pop_data),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_data  (push_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_ctrl   (alu_ctrl),
    .alu_len    (alu_len),
    .alu_result (alu_result),
    .busy       (busy),
    .trap       (trap)
  );

  function automatic logic [W-1:0] ref_alu(
    input logic [4:0]   c,
    input logic         len,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic [W-1:0] x
  );
    logic [W-1:0] r;
    case (c)
      5'b00000: r = a + b;
      5'b00001: r = b - a;
      5'b00100: r = (a != '0) ? x : b;
      5'b00101: r = {63'd0, (a == '0)};
      5'b10110,
      5'b10111: r = (a == '0) ? '1 : b / a;
      5'b11001,
      5'b11010: r = (a == '0) ? b : b % a;
      default:  r = a + b;
    endcase
    if (!len) r = {32'd0, r[31:0]};
    return r;
  endfunction

  assign alu_result = ref_alu(alu_ctrl, alu_len, alu_a, alu_b, alu_c);

  task automatic check(
    input string        tag,
    input logic [W-1:0] obs,
    input logic [W-1:0] exp
  );
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(
    input string        tag,
    input logic [4:0]   code,
    input logic         len,
    input int           pstall,
    input int           qstall,
    input bit           stray,
    input logic [W-1:0] exp,
    input int           exp_pops,
    input int           exp_lat
  );
    int           pops, lat, qcnt;
    bit           done, hs_pop, hs_push;
    logic [W-1:0] pd;
    pops = 0; lat = 0; qcnt = 0; done = 0; pd = '0;
    @(negedge clk);
    check({tag, ".rdy"}, op_ready, 1);
    op_valid = 1'b1; op_code = code; op_len = len;
    pop_ready = 1'b0; push_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0; op_code = ~code; op_len = ~len;
    for (int k = 1; k <= 60 && !done; k++) begin
      pop_data  = (stk.size() > 0) ? stk[0] : '0;
      pop_ready = (k > pstall);
      if (stray && k <= pstall) begin
        op_valid = 1'b1;
        op_code  = 5'b00000;
        check({tag, ".busy"}, busy, 1);
        check({tag, ".nordy"}, op_ready, 0);
      end else begin
        op_valid = 1'b0;
      end
      if (push_valid) begin
        if (lat == 0) begin
          lat = k; pd = push_data;
          cap_a = alu_a; cap_b = alu_b; cap_c = alu_c;
          cap_ctrl = alu_ctrl;
        end else begin
          check({tag, ".hold"}, push_data, pd);
        end
        push_ready = (qcnt >= qstall);
        qcnt++;
      end
      hs_pop  = pop_valid && pop_ready;
      hs_push = push_valid && push_ready;
      @(posedge clk);
      if (hs_pop) begin
        void'(stk.pop_front());
        pops++;
      end
      if (hs_push) done = 1'b1;
      @(negedge clk);
    end
    op_valid = 1'b0; pop_ready = 1'b0; push_ready = 1'b1;
    check({tag, ".done"}, done, 1);
    check({tag, ".data"}, pd, exp);
    check({tag, ".pops"}, pops, exp_pops);
    if (exp_lat > 0) check({tag, ".lat"}, lat, exp_lat);
  endtask

  initial begin
    rst_n = 1'b0; op_valid = 1'b0; op_code = '0; op_len = 1'b0;
    pop_ready = 1'b0; pop_data = '0; push_ready = 1'b1;
    #12;
    check("rst.op_ready", op_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.pop_valid", pop_valid, 0);
    check("rst.push_valid", push_valid, 0);
    check("rst.trap", trap, 0);
    check("rst.push_data", push_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    stk = '{64'd5, 64'd7};
    run_op("add32", 5'b00000, 1'b0, 0, 0, 0, 64'd12, 2, 4);
    check("add32.a", cap_a, 64'd5);
    check("add32.b", cap_b, 64'd7);
    check("add32.c", cap_c, 64'd0);

    stk = '{64'hFFFF_FFFF, 64'd1};
    run_op("add64", 5'b00000, 1'b1, 0, 0, 0,
           64'h1_0000_0000, 2, 4);
    stk = '{64'hFFFF_FFFF, 64'd1};
    run_op("add32w", 5'b00000, 1'b0, 0, 0, 0, 64'd0, 2, 4);

    stk = '{64'd3, 64'd10};
    run_op("sub", 5'b00001, 1'b1, 0, 0, 0, 64'd7, 2, 4);

    stk = '{64'd0, 64'd11, 64'd22};
    run_op("sel0", 5'b00100, 1'b1, 0, 0, 0, 64'd11, 3, 5);
    check("sel0.c", cap_c, 64'd22);
    stk = '{64'd1, 64'd11, 64'd22};
    run_op("sel1", 5'b00100, 1'b1, 0, 0, 0, 64'd22, 3, 5);

    stk = '{64'd5};
    run_op("eqz5", 5'b00101, 1'b1, 0, 0, 0, 64'd0, 1, 3);
    stk = '{64'd0, 64'd99};
    run_op("eqzst", 5'b00101, 1'b1, 3, 2, 1, 64'd1, 1, -1);
    check("eqzst.ctrl", cap_ctrl, 5'b00101);
    check("eqzst.left", stk.size(), 1);
    void'(stk.pop_front());

    stk = '{64'd1, 64'd2};
    run_op("op1c", 5'b11100, 1'b1, 0, 0, 0, 64'd3, 2, 4);

    stk = '{64'd3, 64'd9};
    run_op("divu", 5'b10111, 1'b1, 0, 0, 0, 64'd3, 2, 7);
    stk = '{64'd4, 64'd10};
    run_op("remu", 5'b11010, 1'b1, 0, 0, 0, 64'd2, 2, 7);

`ifdef ALU_DIV_TRAP_EN
    begin
      bit saw_push;
      saw_push = 1'b0;
      stk = '{64'd0, 64'd9};
      @(negedge clk);
      op_valid = 1'b1; op_code = 5'b10111; op_len = 1'b0;
      pop_ready = 1'b1; pop_data = stk[0];
      @(posedge clk);
      @(negedge clk);
      op_valid = 1'b0;
      for (int k = 0; k < 12; k++) begin
        pop_data = (stk.size() > 0) ? stk[0] : '0;
        saw_push = saw_push | push_valid;
        if (pop_valid) void'(stk.pop_front());
        @(negedge clk);
      end
      pop_ready = 1'b0;
      check("dz.trap", trap, 1);
      check("dz.push", saw_push, 0);
      check("dz.op_ready", op_ready, 0);
    end
`else
    stk = '{64'd0, 64'd9};
    run_op("dz", 5'b10111, 1'b0, 0, 0, 0,
           64'h0000_0000_FFFF_FFFF, 2, 7);
    check("dz.trap", trap, 0);
`endif

    stk = '{64'd1, 64'd2};
    @(negedge clk);
    op_valid = 1'b1; op_code = 5'b00001; op_len = 1'b1;
    pop_ready = 1'b1; pop_data = 64'd1;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pop_ready = 1'b0;
    check("rstb.pre", pop_valid, 1);
    rst_n = 1'b0;
    #1;
    check("rstb.pop_valid", pop_valid, 0);
    check("rstb.busy", busy, 0);
    check("rstb.alu_a", alu_a, 0);
    check("rstb.alu_ctrl", alu_ctrl, 0);
    check("rstb.trap", trap, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstb.op_ready", op_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
